// File: rtl/quad_encoder_array_if.sv
// Pin and status bundle for quad_encoder_array: raw encoder pins and clears in,
// debounced levels, step/error strobes and per-channel positions out.
interface quad_encoder_array_if #(
  parameter int unsigned NUM_ENC = 4,
  parameter int unsigned CNT_W   = 8
);
  logic [NUM_ENC-1:0]       encoder_A;
  logic [NUM_ENC-1:0]       encoder_B;
  logic [NUM_ENC-1:0]       count_clr;
  logic [NUM_ENC-1:0]       step_stb;
  logic [NUM_ENC-1:0]       clockwise;
  logic [NUM_ENC-1:0]       err_stb;
  logic [2*NUM_ENC-1:0]     enc_value;
  logic [CNT_W*NUM_ENC-1:0] position;

  modport master (
    output encoder_A, encoder_B, count_clr,
    input  step_stb, clockwise, err_stb, enc_value, position
  );

  modport slave (
    input  encoder_A, encoder_B, count_clr,
    output step_stb, clockwise, err_stb, enc_value, position
  );
endinterface

// File: rtl/quad_encoder_array.sv
// N-channel quadrature decoder: 2-flop sync, tick-based debounce, Gray decode, position count.
// Define ENC_SATURATE_EN to saturate position at its signed limits instead of wrapping.
module quad_encoder_array #(
  parameter int unsigned NUM_ENC           = 4,
  parameter int unsigned SAMPLE_DIV        = 16383,
  parameter int unsigned DEB_DEPTH         = 4,
  parameter int unsigned QUARTERS_PER_STEP = 4,
  parameter int unsigned CNT_W             = 8
) (
  input logic                clk,
  input logic                reset,
  quad_encoder_array_if.slave bus
);

  localparam int unsigned DivW = $clog2(SAMPLE_DIV);
  // Sub-step accumulator is 5-bit two's complement; +/-Q encoded as raw patterns.
  localparam logic [4:0] QPos = 5'(QUARTERS_PER_STEP);
  localparam logic [4:0] QNeg = 5'(32 - QUARTERS_PER_STEP);
  localparam logic [CNT_W-1:0] PosMax = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] PosMin = {1'b1, {(CNT_W-1){1'b0}}};

  // Gray code {B,A} to rotational index: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_pos(input logic [1:0] ba);
    return {ba[1], ba[1] ^ ba[0]};
  endfunction

  function automatic logic [CNT_W-1:0] pos_inc(input logic [CNT_W-1:0] p);
`ifdef ENC_SATURATE_EN
    return (p == PosMax) ? p : p + CNT_W'(1);
`else
    return p + CNT_W'(1);
`endif
  endfunction

  function automatic logic [CNT_W-1:0] pos_dec(input logic [CNT_W-1:0] p);
`ifdef ENC_SATURATE_EN
    return (p == PosMin) ? p : p - CNT_W'(1);
`else
    return p - CNT_W'(1);
`endif
  endfunction

  // Sample tick divider
  logic [DivW-1:0] div_q;
  logic            tick;

  assign tick = (div_q == DivW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  // Synchronisers
  logic [NUM_ENC-1:0] a_meta_q, a_sync_q, b_meta_q, b_sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_meta_q <= '0;
      a_sync_q <= '0;
      b_meta_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_meta_q <= bus.encoder_A;
      a_sync_q <= a_meta_q;
      b_meta_q <= bus.encoder_B;
      b_sync_q <= b_meta_q;
    end
  end

  // Debounce and decode
  logic [NUM_ENC-1:0][DEB_DEPTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [NUM_ENC-1:0][1:0]           enc_q, enc_d, cand, g_diff;
  logic [NUM_ENC-1:0]                init_q, init_d;
  logic [NUM_ENC-1:0]                a_stable, b_stable;
  logic [NUM_ENC-1:0]                ev_cw_q, ev_cw_d, ev_ccw_q, ev_ccw_d, ev_err_q, ev_err_d;

  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    enc_d    = enc_q;
    init_d   = init_q;
    cand     = enc_q;
    g_diff   = '0;
    a_stable = '0;
    b_stable = '0;
    ev_cw_d  = '0;
    ev_ccw_d = '0;
    ev_err_d = '0;
    for (int i = 0; i < NUM_ENC; i++) begin
      if (tick) begin
        a_sh_d[i] = {a_sh_q[i][DEB_DEPTH-2:0], a_sync_q[i]};
        b_sh_d[i] = {b_sh_q[i][DEB_DEPTH-2:0], b_sync_q[i]};
      end
      a_stable[i] = (&a_sh_d[i]) | ~(|a_sh_d[i]);
      b_stable[i] = (&b_sh_d[i]) | ~(|b_sh_d[i]);
      cand[i][0]  = a_stable[i] ? a_sh_d[i][0] : enc_q[i][0];
      cand[i][1]  = b_stable[i] ? b_sh_d[i][0] : enc_q[i][1];
      g_diff[i]   = gray_pos(cand[i]) - gray_pos(enc_q[i]);
      if (tick) begin
        if (!init_q[i]) begin
          // First fully stable sample only establishes the reference level.
          if (a_stable[i] && b_stable[i]) begin
            enc_d[i]  = cand[i];
            init_d[i] = 1'b1;
          end
        end else begin
          enc_d[i]    = cand[i];
          ev_cw_d[i]  = (g_diff[i] == 2'd1);
          ev_ccw_d[i] = (g_diff[i] == 2'd3);
          ev_err_d[i] = (g_diff[i] == 2'd2);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      enc_q    <= '0;
      init_q   <= '0;
      ev_cw_q  <= '0;
      ev_ccw_q <= '0;
      ev_err_q <= '0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      enc_q    <= enc_d;
      init_q   <= init_d;
      ev_cw_q  <= ev_cw_d;
      ev_ccw_q <= ev_ccw_d;
      ev_err_q <= ev_err_d;
    end
  end

  // Step accumulation and position
  logic [NUM_ENC-1:0][4:0]       acc_q, acc_d, acc_sum;
  logic [NUM_ENC-1:0][CNT_W-1:0] pos_q, pos_d;
  logic [NUM_ENC-1:0]            step_q, step_d, err_q, err_d, cw_q, cw_d, up, dn;

  always_comb begin
    acc_d   = acc_q;
    acc_sum = acc_q;
    pos_d   = pos_q;
    step_d  = '0;
    err_d   = '0;
    cw_d    = cw_q;
    up      = '0;
    dn      = '0;
    for (int i = 0; i < NUM_ENC; i++) begin
      acc_sum[i] = acc_q[i] + (ev_cw_q[i] ? 5'd1 : (ev_ccw_q[i] ? 5'h1f : 5'd0));
      up[i]      = (acc_sum[i] == QPos);
      dn[i]      = (acc_sum[i] == QNeg);
      step_d[i]  = up[i] | dn[i];
      err_d[i]   = ev_err_q[i];
      acc_d[i]   = (up[i] | dn[i]) ? 5'd0 : acc_sum[i];
      if (up[i]) begin
        cw_d[i]  = 1'b1;
        pos_d[i] = pos_inc(pos_q[i]);
      end else if (dn[i]) begin
        cw_d[i]  = 1'b0;
        pos_d[i] = pos_dec(pos_q[i]);
      end
      // Clear overrides the count but the step is still reported.
      if (bus.count_clr[i]) begin
        acc_d[i] = '0;
        pos_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q  <= '0;
      pos_q  <= '0;
      step_q <= '0;
      err_q  <= '0;
      cw_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      pos_q  <= pos_d;
      step_q <= step_d;
      err_q  <= err_d;
      cw_q   <= cw_d;
    end
  end

  assign bus.step_stb  = step_q;
  assign bus.err_stb   = err_q;
  assign bus.clockwise = cw_q;
  assign bus.enc_value = enc_q;
  assign bus.position  = pos_q;

endmodule
